mcu51_uart_rx: RTL

MCU51_UART_RX -- requirements
Module: mcu51_uart_rx

---
 rtl/mcu51_pkg.sv | 20 ++
 rtl/sync_bit.sv | 27 ++
 rtl/mcu51_uart_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mcu51_pkg.sv
// Shared definitions for the 8051-style serial receiver: FSM states,
// SCON bit positions and frame geometry.
package mcu51_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // SCON bit positions touched by the receiver.
  localparam int SCON_RI  = 0;
  localparam int SCON_RB8 = 2;
  localparam int SCON_REN = 4;

  // Mode 1 frame: 8 data bits between one start and one stop bit.
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-stage synchronizer for one asynchronous input. It resets to 1 so an
// idle-high line shows no spurious edge when reset is released.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge CLK) begin
    // NOTE: flops are written with <= so each stage captures its neighbour's
    // pre-edge value; blocking = would collapse the chain into a single stage.
    if (reset) begin
      ff <= '1;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/mcu51_uart_rx.sv
// 8051 mode-1 UART receiver: start-bit qualification at mid-bit, centred
// data and stop sampling, SBUF/RB8/RI update with overrun detection.
module mcu51_uart_rx
  import mcu51_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ren,
  input  logic       ri_clr,
  output logic [7:0] sbuf,
  output logic       rb8,
  output logic       ri,
  output logic       busy,
  output logic       ovr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rxs;
  logic                 rxs_prev;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 data_smp;
  logic                 stop_smp;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK  (CLK),
    .reset(reset),
    .d    (rxd),
    .q    (rxs)
  );

  // Next-state and sample strobes for the frame FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would make synthesis infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    data_smp = 1'b0;
    stop_smp = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (ren && rxs_prev && !rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          data_smp = 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          stop_smp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dropping ren abandons any frame in progress without touching outputs.
    if (!ren && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bit_d    = '0;
      data_smp = 1'b0;
      stop_smp = 1'b0;
    end
  end

  // FSM state, cycle counter and bit counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // Edge-detect history, data shift register and accepted-byte outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rxs_prev <= 1'b1;
      // NOTE: shift_q is a plain flop vector, so it takes the reset like any
      // other register; a RAM-style array would be left unreset instead.
      shift_q  <= '0;
      sbuf     <= '0;
      rb8      <= 1'b0;
    end else begin
      rxs_prev <= rxs;
      if (data_smp) begin
        shift_q[bit_q] <= rxs;
      end
      if (stop_smp && !ri) begin
        sbuf <= shift_q;
        rb8  <= rxs;
      end
    end
  end

  // Sticky RI and overrun flags; a set in the same cycle beats ri_clr.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ri  <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (ri_clr) begin
        ri  <= 1'b0;
        ovr <= 1'b0;
      end
      if (stop_smp) begin
        if (!ri) begin
          ri <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
